// File: rtl/dvp_tx_generator.sv
// DVP transmit generator: serialises RGB565 pixels onto an 8-bit DVP bus
// with VSYNC/HREF framing, one byte per clock, high byte first.
module dvp_tx_generator #(
  parameter int unsigned DVP_DATA_W = 8,
  parameter int unsigned RGB_PXL_W  = 16,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned HBLANK_CYC = 16,
  parameter int unsigned VSYNC_CYC  = 8,
  parameter int unsigned VBLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcr_cam_start_i,
  input  logic [RGB_PXL_W-1:0]  rgb_pxl_i,
  input  logic                  rgb_pxl_vld_i,
  output logic                  rgb_pxl_rdy_o,
  output logic [DVP_DATA_W-1:0] dvp_data_o,
  output logic                  dvp_de_o,
  output logic                  dvp_href_o,
  output logic                  dvp_vsync_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam int unsigned LINE_CYC = 2 * IMG_W;
  localparam int unsigned MAX_A    = (LINE_CYC > HBLANK_CYC) ? LINE_CYC : HBLANK_CYC;
  localparam int unsigned MAX_B    = (VSYNC_CYC > VBLANK_CYC) ? VSYNC_CYC : VBLANK_CYC;
  localparam int unsigned CYC_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);
  localparam int unsigned LINE_W   = $clog2(IMG_H + 1);

  localparam logic [CYC_W-1:0]  VSYNC_LAST  = CYC_W'(VSYNC_CYC - 1);
  localparam logic [CYC_W-1:0]  VBLANK_LAST = CYC_W'(VBLANK_CYC - 1);
  localparam logic [CYC_W-1:0]  LINE_LAST   = CYC_W'(LINE_CYC - 1);
  localparam logic [CYC_W-1:0]  HBLANK_LAST = CYC_W'(HBLANK_CYC - 1);
  localparam logic [LINE_W-1:0] LINES       = LINE_W'(IMG_H);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBLANK,
    ST_ACTIVE,
    ST_HBLANK
  } state_e;

  // State and counters describe the cycle currently shown on the DVP outputs.
  state_e                  state_q, state_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [DVP_DATA_W-1:0]   lo_q, lo_d;
  logic [DVP_DATA_W-1:0]   data_d;
  logic                    frame_done_d;
  logic                    underrun_d;
  logic                    rdy_c;

  assign rgb_pxl_rdy_o = rdy_c;

  // Next-state, counter and pixel-slot decode; rdy depends only on state/phase.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q + CYC_W'(1);
    line_d       = line_q;
    rdy_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (dcr_cam_start_i) begin
          state_d = ST_VSYNC;
          line_d  = '0;
        end
      end
      ST_VSYNC: begin
        if (cyc_q == VSYNC_LAST) begin
          state_d = ST_VBLANK;
          cyc_d   = '0;
        end
      end
      ST_VBLANK: begin
        if (cyc_q == VBLANK_LAST) begin
          state_d = ST_ACTIVE;
          cyc_d   = '0;
          rdy_c   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cyc_q == LINE_LAST) begin
          state_d = ST_HBLANK;
          cyc_d   = '0;
          line_d  = line_q + LINE_W'(1);
        end else begin
          rdy_c = cyc_q[0];
        end
      end
      ST_HBLANK: begin
        if (cyc_q == HBLANK_LAST) begin
          cyc_d = '0;
          if (line_q < LINES) begin
            state_d = ST_ACTIVE;
            rdy_c   = 1'b1;
          end else if (dcr_cam_start_i) begin
            state_d = ST_VSYNC;
            line_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        line_d  = '0;
      end
    endcase
  end

  // Output byte selection: high byte on accept, buffered low byte next cycle.
  always_comb begin
    data_d       = '0;
    lo_d         = lo_q;
    underrun_d   = rdy_c & ~rgb_pxl_vld_i;
    frame_done_d = (state_d == ST_HBLANK) && (cyc_d == HBLANK_LAST) && (line_d == LINES);
    if (rdy_c) begin
      if (rgb_pxl_vld_i) begin
        data_d = rgb_pxl_i[RGB_PXL_W-1 -: DVP_DATA_W];
        lo_d   = rgb_pxl_i[DVP_DATA_W-1:0];
      end else begin
        lo_d   = '0;
      end
    end else if (state_d == ST_ACTIVE) begin
      data_d = lo_q;
    end
  end

  // State, counters and all DVP outputs registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      line_q       <= '0;
      lo_q         <= '0;
      dvp_data_o   <= '0;
      dvp_de_o     <= 1'b0;
      dvp_href_o   <= 1'b0;
      dvp_vsync_o  <= 1'b0;
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      line_q       <= line_d;
      lo_q         <= lo_d;
      dvp_data_o   <= data_d;
      dvp_de_o     <= (state_d == ST_ACTIVE);
      dvp_href_o   <= (state_d == ST_ACTIVE);
      dvp_vsync_o  <= (state_d == ST_VSYNC);
      frame_done_o <= frame_done_d;
      underrun_o   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dvp_tx_generator.sv
// Bench for dvp_tx_generator: frame-position reference model plus directed scenarios.
module tb_dvp_tx_generator;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int HB    = 3;
  localparam int VS    = 2;
  localparam int VB    = 2;
  localparam int LINE  = 2 * W + HB;
  localparam int FLEN  = VS + VB + H * LINE;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] pxl;
  logic        vld;
  logic        rdy;
  logic [7:0]  dvp_data;
  logic        dvp_de, dvp_href, dvp_vsync, frame_done, underrun;

  dvp_tx_generator #(
    .DVP_DATA_W(8), .RGB_PXL_W(16), .IMG_W(W), .IMG_H(H),
    .HBLANK_CYC(HB), .VSYNC_CYC(VS), .VBLANK_CYC(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dcr_cam_start_i(start),
    .rgb_pxl_i(pxl), .rgb_pxl_vld_i(vld), .rgb_pxl_rdy_o(rdy),
    .dvp_data_o(dvp_data), .dvp_de_o(dvp_de), .dvp_href_o(dvp_href),
    .dvp_vsync_o(dvp_vsync), .frame_done_o(frame_done), .underrun_o(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: position within the frame (-1 = idle) and expected outputs.
  int          fpos;
  logic [7:0]  e_data, lo_pend;
  logic        e_de, e_href, e_vs, e_fd, e_ur;
  logic [15:0] pend;
  logic [15:0] seq_tbl [8];
  int          seq_idx;
  int          vmode, drop_slot, slot_cnt;
  int          dut_hs, fd_cnt, ur_cnt, rdy_cnt, href_cnt;
  logic [7:0]  blog [$];

  function automatic bit is_active(input int k);
    int j;
    if (k < 0) return 1'b0;
    j = k - VS - VB;
    if (j < 0) return 1'b0;
    return (j % LINE) < 2 * W;
  endfunction

  function automatic bit slot_start(input int k);
    if (!is_active(k)) return 1'b0;
    return (((k - VS - VB) % LINE) % 2) == 0;
  endfunction

  function automatic int next_pos(input int k, input bit st);
    if (k < 0 || k == FLEN - 1) return st ? 0 : -1;
    return k + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic next_pixel();
    if (seq_idx < 8) begin
      pend = seq_tbl[seq_idx];
      seq_idx++;
    end else begin
      pend = 16'($urandom);
    end
  endtask

  // One clock: check this cycle's outputs, drive inputs for the next edge, advance the model.
  task automatic step(input bit r, input bit st);
    bit v;
    bit rdy_e;
    int nfp;
    @(negedge clk);
    chk("dvp_outputs", {19'd0, dvp_data, dvp_de, dvp_href, dvp_vsync, frame_done, underrun},
        {19'd0, e_data, e_de, e_href, e_vs, e_fd, e_ur});
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (dvp_href) href_cnt++;
    if (fpos >= VS + VB && fpos < VS + VB + 2 * W) blog.push_back(dvp_data);
    rdy_e = slot_start(next_pos(fpos, 1'b0));
    chk("rgb_pxl_rdy", {31'd0, rdy}, {31'd0, rdy_e});
    case (vmode)
      1:       v = ($urandom_range(99) < 70);
      2:       v = !(rdy_e && slot_cnt == drop_slot);
      default: v = 1'b1;
    endcase
    rst_n = r;
    start = st;
    vld   = v;
    pxl   = pend;
    if (r && rdy && v) dut_hs++;
    if (!r) begin
      fpos = -1; e_data = '0; e_de = 0; e_href = 0; e_vs = 0; e_fd = 0; e_ur = 0; lo_pend = '0;
    end else begin
      nfp    = next_pos(fpos, st);
      e_vs   = (nfp >= 0 && nfp < VS);
      e_href = is_active(nfp);
      e_de   = e_href;
      e_fd   = (nfp == FLEN - 1);
      e_ur   = 1'b0;
      e_data = '0;
      if (rdy_e) begin
        rdy_cnt++;
        slot_cnt++;
        if (v) begin
          e_data  = pend[15:8];
          lo_pend = pend[7:0];
          next_pixel();
        end else begin
          e_ur    = 1'b1;
          lo_pend = '0;
        end
      end else if (e_href) begin
        e_data = lo_pend;
      end
      fpos = nfp;
    end
  endtask

  task automatic clr();
    dut_hs = 0; fd_cnt = 0; ur_cnt = 0; rdy_cnt = 0; href_cnt = 0; slot_cnt = 0;
    blog.delete();
  endtask

  initial begin
    int guard;
    logic [7:0] exp_b [8];
    seq_tbl = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    rst_n = 1'b0; start = 1'b1; vld = 1'b0; pxl = '0;
    fpos = -1; e_data = '0; e_de = 0; e_href = 0; e_vs = 0; e_fd = 0; e_ur = 0; lo_pend = '0;
    vmode = 0; drop_slot = 0; seq_idx = 0; pend = '0;
    clr();

    // Reset with start high, then idle with start low.
    repeat (3) step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0);
    chk("idle_no_rdy", 32'(rdy_cnt), 32'd0);
    chk("idle_no_href", 32'(href_cnt), 32'd0);

    // Single frame with a one-cycle start pulse and a known pixel sequence.
    clr(); seq_idx = 0; next_pixel(); vmode = 0;
    step(1'b1, 1'b1);
    repeat (FLEN + 5) step(1'b1, 1'b0);
    chk("single_frame_done", 32'(fd_cnt), 32'd1);
    chk("single_handshakes", 32'(dut_hs), 32'd8);
    chk("single_href_cycles", 32'(href_cnt), 32'd16);
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    chk("single_line0_len", 32'(blog.size()), 32'd8);
    if (blog.size() == 8)
      for (int i = 0; i < 8; i++) chk("single_line0_byte", 32'(blog[i]), 32'(exp_b[i]));

    // Continuous mode: start held across a frame boundary, random pixels.
    clr(); seq_idx = 8; next_pixel(); vmode = 0;
    repeat (FLEN + 2) step(1'b1, 1'b1);
    repeat (FLEN + 4) step(1'b1, 1'b0);
    chk("cont_frame_done", 32'(fd_cnt), 32'd2);
    chk("cont_handshakes", 32'(dut_hs), 32'd16);

    // Underrun in the third pixel window.
    clr(); seq_idx = 0; next_pixel(); vmode = 2; drop_slot = 2;
    step(1'b1, 1'b1);
    repeat (FLEN + 4) step(1'b1, 1'b0);
    chk("underrun_pulses", 32'(ur_cnt), 32'd1);
    chk("underrun_handshakes", 32'(dut_hs), 32'd7);
    chk("underrun_href_cycles", 32'(href_cnt), 32'd16);
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h9A, 8'hBC};
    chk("underrun_line0_len", 32'(blog.size()), 32'd8);
    if (blog.size() == 8)
      for (int i = 0; i < 8; i++) chk("underrun_line0_byte", 32'(blog[i]), 32'(exp_b[i]));

    // Randomly gapped source over two frames.
    clr(); seq_idx = 8; next_pixel(); vmode = 1;
    repeat (FLEN + 2) step(1'b1, 1'b1);
    repeat (FLEN + 4) step(1'b1, 1'b0);
    chk("rand_slots", 32'(dut_hs + ur_cnt), 32'd16);
    chk("rand_underruns", 32'(ur_cnt), 32'(16 - dut_hs));
    chk("rand_frame_done", 32'(fd_cnt), 32'd2);

    // Mid-frame reset during line 1, then a clean frame.
    clr(); seq_idx = 0; next_pixel(); vmode = 0;
    step(1'b1, 1'b1);
    guard = 0;
    while (fpos != VS + VB + LINE + 2 && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("midrst_reached_line1", 32'(fpos), 32'(VS + VB + LINE + 2));
    step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("midrst_outputs_zero",
        {22'd0, dvp_data, dvp_de, dvp_href, dvp_vsync, frame_done, underrun, rdy}, 32'd0);
    clr(); seq_idx = 0; next_pixel();
    step(1'b1, 1'b1);
    repeat (FLEN + 4) step(1'b1, 1'b0);
    chk("midrst_clean_done", 32'(fd_cnt), 32'd1);
    chk("midrst_clean_hs", 32'(dut_hs), 32'd8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
